bitcoin_hash_multi_batch: RTL and testbench

//  Parametrised nonce-search engine for an 80-byte (20-word) Bitcoin header in shared memory.
//  - Runs the header-only first SHA-256 block once.
//  - Sweeps nonce_count nonces from nonce_base in batches of NUM_LANES parallel lanes.
//  - Per lane: second block, then SHA-256 of the 256-bit digest. Writes digest word h0 per nonce.
//  - Compares h0 against a target and reports the lowest qualifying nonce; can stop on the first hit.

---
 rtl/bitcoin_hash_pkg.sv | 58 +++++
 rtl/bitcoin_hash_multi_batch_if.sv | 13 +
 rtl/bitcoin_hash_multi_batch_lane.sv | 56 +++++
 rtl/bitcoin_hash_multi_batch.sv | 181 ++++++++++++++++++
 tb/tb_bitcoin_hash_multi_batch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bitcoin_hash_pkg.sv
// Shared types, SHA-256 constants and round helpers for the nonce-search engine.
package bitcoin_hash_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_READ, ST_P1_BLK, ST_P1_CMP, ST_P2_BLK,
        ST_P2_CMP, ST_P3_BLK, ST_P3_CMP, ST_WRITE
    } state_t;

    localparam logic [31:0] PAD_ONE   = 32'h8000_0000;  // first padding word after the message
    localparam logic [31:0] LEN_P2    = 32'd640;        // 80-byte header, in bits
    localparam logic [31:0] LEN_P3    = 32'd256;        // 32-byte digest, in bits
    localparam int          READ_LAST = 20;             // 20 addresses + 1 trailing capture cycle
    localparam int          CMP_LAST  = 65;             // 64 rounds, 1 settle, 1 add
    localparam int          ROUNDS    = 64;

    // Index 0 holds H0 (working variable a); the literal lists H7 first.
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    // One compression round; s[0]..s[7] = a..h.
    function automatic logic [7:0][31:0] sha256_op(input logic [7:0][31:0] s,
                                                   input logic [31:0] w, input logic [31:0] k);
        logic [31:0] s0, s1, ch, maj, t1, t2;
        s1  = rightrotate(s[4], 5'd6) ^ rightrotate(s[4], 5'd11) ^ rightrotate(s[4], 5'd25);
        ch  = (s[4] & s[5]) ^ (~s[4] & s[6]);
        t1  = s[7] + s1 + ch + k + w;
        s0  = rightrotate(s[0], 5'd2) ^ rightrotate(s[0], 5'd13) ^ rightrotate(s[0], 5'd22);
        maj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
        t2  = s0 + maj;
        return {s[6], s[5], s[4], s[3] + t1, s[2], s[1], s[0], t1 + t2};
    endfunction

    // Next schedule word from a window whose entry 0 is W[t].
    function automatic logic [31:0] wtnew(input logic [15:0][31:0] w);
        logic [31:0] s0, s1;
        s0 = rightrotate(w[1], 5'd7) ^ rightrotate(w[1], 5'd18) ^ (w[1] >> 3);
        s1 = rightrotate(w[14], 5'd17) ^ rightrotate(w[14], 5'd19) ^ (w[14] >> 10);
        return w[0] + s0 + w[9] + s1;
    endfunction

endpackage

// File: rtl/bitcoin_hash_multi_batch_if.sv
// Shared-memory port of the nonce-search engine.
// Protocol: no valid/ready backpressure. mem_we qualifies mem_addr/mem_write_data for
// exactly the cycle it is high; mem_read_data returns the word at mem_addr one cycle later.
interface bitcoin_hash_multi_batch_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (output mem_clk, mem_we, mem_addr, mem_write_data, input mem_read_data);
    modport slave  (input mem_clk, mem_we, mem_addr, mem_write_data, output mem_read_data);
endinterface

// File: rtl/bitcoin_hash_multi_batch_lane.sv
// One SHA-256 compression engine with a rolling 16-word schedule window.
// digest is the chaining value plus the working variables, valid once 64 steps are done.
module sha256_lane
    import bitcoin_hash_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [7:0][31:0] init,
    input  logic [15:0][31:0] w_in,
    input  logic             step,
    output logic [7:0][31:0] digest
);
    logic [7:0][31:0]  work_q, work_d, hin_q, hin_d;
    logic [15:0][31:0] w_q, w_d;
    logic [5:0]        t_q, t_d;

    // Load a new block, or advance one round and slide the schedule window.
    always_comb begin
        work_d = work_q;
        hin_d  = hin_q;
        w_d    = w_q;
        t_d    = t_q;
        if (load) begin
            work_d = init;
            hin_d  = init;
            w_d    = w_in;
            t_d    = '0;
        end else if (step) begin
            work_d = sha256_op(work_q, w_q[0], K[t_q]);
            w_d    = {wtnew(w_q), w_q[15:1]};
            t_d    = t_q + 6'd1;
        end
    end

    // Final feed-forward add of the chaining value.
    always_comb begin
        digest = '0;
        for (int i = 0; i < 8; i++) digest[i] = hin_q[i] + work_q[i];
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            hin_q  <= '0;
            w_q    <= '0;
            t_q    <= '0;
        end else begin
            work_q <= work_d;
            hin_q  <= hin_d;
            w_q    <= w_d;
            t_q    <= t_d;
        end
    end
endmodule

// File: rtl/bitcoin_hash_multi_batch.sv
// Nonce-search engine: reads an 80-byte header, computes its midstate once, then
// hashes NUM_LANES nonces per batch with SHA-256d and writes h0 of each result.
module bitcoin_hash_multi_batch
    import bitcoin_hash_pkg::*;
#(
    parameter int NUM_LANES = 8,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [15:0]      message_addr,
    input  logic [15:0]      output_addr,
    input  logic [31:0]      nonce_base,
    input  logic [CNT_W-1:0] nonce_count,
    input  logic [31:0]      target,
    input  logic             stop_on_found,
    output logic             done,
    output logic             found,
    output logic [31:0]      found_nonce,
    output state_t           state_dbg,
    bitcoin_hash_multi_batch_if.master mem
);
    // One extra bit so batch_base + NUM_LANES never wraps near the top of the count range.
    typedef logic [CNT_W:0] idx_t;

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [15:0]       msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0]       nonce_base_q, nonce_base_d, target_q, target_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              stop_q, stop_d;
    idx_t              idx_base_q, idx_base_d;
    logic [18:0][31:0] hdr_q, hdr_d;  // word 19 is the nonce slot and is replaced per lane
    logic [7:0][31:0]  mid_q, mid_d;
    logic              found_q, found_d, mem_we_q, mem_we_d;
    logic [31:0]       found_nonce_q, found_nonce_d, mem_wdata_q, mem_wdata_d;
    logic [15:0]       mem_addr_q, mem_addr_d;

    logic [NUM_LANES-1:0][7:0][31:0] lane_digest;
    logic        lane_load, lane_step, lane_valid;
    logic [31:0] sel_h0;
    idx_t        idx, next_base;

    assign lane_load = (state_q == ST_P1_BLK) || (state_q == ST_P2_BLK) || (state_q == ST_P3_BLK);
    assign lane_step = ((state_q == ST_P1_CMP) || (state_q == ST_P2_CMP) || (state_q == ST_P3_CMP))
                       && (cnt_q < 7'(ROUNDS));

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [7:0][31:0]  init;
        logic [15:0][31:0] w_in;
        logic [31:0]       nonce;

        assign nonce = nonce_base_q + 32'(idx_base_q) + 32'(l);

        // Block/chaining selection: header block, nonce block, or digest-of-digest block.
        always_comb begin
            init = IV;
            w_in = '0;
            if (state_q == ST_P1_BLK) begin
                w_in = hdr_q[15:0];
            end else if (state_q == ST_P2_BLK) begin
                init     = mid_q;
                w_in[0]  = hdr_q[16];
                w_in[1]  = hdr_q[17];
                w_in[2]  = hdr_q[18];
                w_in[3]  = nonce;
                w_in[4]  = PAD_ONE;
                w_in[15] = LEN_P2;
            end else begin
                w_in[7:0] = lane_digest[l];
                w_in[8]   = PAD_ONE;
                w_in[15]  = LEN_P3;
            end
        end

        sha256_lane u_lane (
            .clk    (clk),
            .rst_n  (reset_n),
            .load   (lane_load),
            .init   (init),
            .w_in   (w_in),
            .step   (lane_step),
            .digest (lane_digest[l])
        );
    end

    // h0 of the lane being written this cycle.
    always_comb begin
        sel_h0 = '0;
        for (int l = 0; l < NUM_LANES; l++)
            if (cnt_q == 7'(l)) sel_h0 = lane_digest[l][0];
    end

    // Sequencer: header read, midstate, per-batch P2/P3 and write-back, hit tracking.
    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;
        msg_addr_d = msg_addr_q;  out_addr_d = out_addr_q;  nonce_base_d = nonce_base_q;
        target_d = target_q;  count_d = count_q;  stop_d = stop_q;  idx_base_d = idx_base_q;
        hdr_d = hdr_q;  mid_d = mid_q;  found_d = found_q;  found_nonce_d = found_nonce_q;
        mem_we_d = 1'b0;  mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;
        idx = '0;  next_base = '0;  lane_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: if (start) begin
                msg_addr_d = message_addr;  out_addr_d = output_addr;  nonce_base_d = nonce_base;
                target_d = target;  count_d = nonce_count;  stop_d = stop_on_found;
                idx_base_d = '0;  found_d = 1'b0;  found_nonce_d = '0;
                mem_addr_d = message_addr;  cnt_d = '0;  state_d = ST_READ;
            end
            ST_READ: begin
                if (cnt_q != 7'd0 && cnt_q < 7'd20) hdr_d[5'(cnt_q - 7'd1)] = mem.mem_read_data;
                if (cnt_q < 7'd19) mem_addr_d = msg_addr_q + 16'(cnt_q) + 16'd1;
                if (cnt_q == 7'(READ_LAST)) begin
                    cnt_d   = '0;
                    state_d = (count_q == '0) ? ST_IDLE : ST_P1_BLK;
                end else cnt_d = cnt_q + 7'd1;
            end
            ST_P1_BLK: state_d = ST_P1_CMP;
            ST_P2_BLK: state_d = ST_P2_CMP;
            ST_P3_BLK: state_d = ST_P3_CMP;
            ST_P1_CMP, ST_P2_CMP, ST_P3_CMP: begin
                if (cnt_q == 7'(CMP_LAST)) begin
                    cnt_d = '0;
                    if (state_q == ST_P1_CMP) begin
                        mid_d   = lane_digest[0];
                        state_d = ST_P2_BLK;
                    end else state_d = (state_q == ST_P2_CMP) ? ST_P3_BLK : ST_WRITE;
                end else cnt_d = cnt_q + 7'd1;
            end
            ST_WRITE: begin
                if (cnt_q < 7'(NUM_LANES)) begin
                    idx         = idx_base_q + idx_t'(cnt_q);
                    lane_valid  = idx < {1'b0, count_q};
                    mem_we_d    = lane_valid;
                    mem_addr_d  = out_addr_q + 16'(idx);
                    mem_wdata_d = sel_h0;
                    // Lanes are visited in nonce order, so the first hit is the one to keep.
                    if (lane_valid && (sel_h0 < target_q) && !found_q) begin
                        found_d       = 1'b1;
                        found_nonce_d = nonce_base_q + 32'(idx);
                    end
                    cnt_d = cnt_q + 7'd1;
                end else begin
                    next_base = idx_base_q + idx_t'(NUM_LANES);
                    cnt_d     = '0;
                    if ((next_base >= {1'b0, count_q}) || (stop_q && found_q)) state_d = ST_IDLE;
                    else begin
                        idx_base_d = next_base;
                        state_d    = ST_P2_BLK;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;  cnt_q <= '0;  msg_addr_q <= '0;  out_addr_q <= '0;
            nonce_base_q <= '0;  target_q <= '0;  count_q <= '0;  stop_q <= 1'b0;
            idx_base_q <= '0;  hdr_q <= '0;  mid_q <= '0;  found_q <= 1'b0;
            found_nonce_q <= '0;  mem_we_q <= 1'b0;  mem_addr_q <= '0;  mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  msg_addr_q <= msg_addr_d;  out_addr_q <= out_addr_d;
            nonce_base_q <= nonce_base_d;  target_q <= target_d;  count_q <= count_d;  stop_q <= stop_d;
            idx_base_q <= idx_base_d;  hdr_q <= hdr_d;  mid_q <= mid_d;  found_q <= found_d;
            found_nonce_q <= found_nonce_d;  mem_we_q <= mem_we_d;  mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign done               = (state_q == ST_IDLE);
    assign found              = found_q;
    assign found_nonce        = found_nonce_q;
    assign state_dbg          = state_q;
    assign mem.mem_clk        = clk;
    assign mem.mem_we         = mem_we_q;
    assign mem.mem_addr       = mem_addr_q;
    assign mem.mem_write_data = mem_wdata_q;
endmodule

// File: tb/tb_bitcoin_hash_multi_batch.sv
// Bench for bitcoin_hash_multi_batch: random headers in a behavioural memory, reference
// SHA-256d computed with a full 64-word schedule, write stream compared in order.
module tb_bitcoin_hash_multi_batch;
    localparam int NL     = 8;
    localparam int CW     = 16;
    localparam int BUDGET = 4000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, stop_on_found = 1'b0;
    logic [15:0] message_addr = '0, output_addr = '0;
    logic [31:0] nonce_base = '0, target = '0;
    logic [CW-1:0] nonce_count = '0;
    logic        done, found;
    logic [31:0] found_nonce;
    bitcoin_hash_pkg::state_t state_dbg;

    bitcoin_hash_multi_batch_if bus ();

    bitcoin_hash_multi_batch #(.NUM_LANES(NL), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .message_addr(message_addr),
        .output_addr(output_addr), .nonce_base(nonce_base), .nonce_count(nonce_count),
        .target(target), .stop_on_found(stop_on_found), .done(done), .found(found),
        .found_nonce(found_nonce), .state_dbg(state_dbg), .mem(bus)
    );

    // ---------------- memory model ----------------
    logic [31:0] mem [65536];
    logic [31:0] rd_q = '0;
    logic [47:0] act_q [$];
    always @(posedge clk) rd_q <= mem[bus.mem_addr];
    assign bus.mem_read_data = rd_q;
    always @(posedge clk) if (bus.mem_we === 1'b1) act_q.push_back({bus.mem_addr, bus.mem_write_data});

    // ---------------- reference model ----------------
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] IVW [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                       32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic [31:0] hdr [20];
    logic [47:0] exp_q [$];

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [7:0][31:0] iv_vec();
        logic [7:0][31:0] v;
        for (int i = 0; i < 8; i++) v[i] = IVW[i];
        return v;
    endfunction

    function automatic logic [7:0][31:0] compress(input logic [7:0][31:0] hv, input logic [15:0][31:0] m);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [7:0][31:0] r;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = hv[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = hv[i] + v[i];
        return r;
    endfunction

    // SHA256d of the header with word 19 replaced by the nonce; returns h0 of the outer hash.
    function automatic logic [31:0] h0_of(input logic [7:0][31:0] mid, input logic [31:0] nonce);
        logic [15:0][31:0] b;
        logic [7:0][31:0] d1, d2;
        b = '0;
        b[0] = hdr[16]; b[1] = hdr[17]; b[2] = hdr[18]; b[3] = nonce;
        b[4] = 32'h8000_0000; b[15] = 32'd640;
        d1 = compress(mid, b);
        b = '0;
        for (int i = 0; i < 8; i++) b[i] = d1[i];
        b[8] = 32'h8000_0000; b[15] = 32'd256;
        d2 = compress(iv_vec(), b);
        return d2[0];
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run(input logic [31:0] base, input int count, input logic [31:0] tgt,
                       input logic stop, input string name, input int rst_at);
        logic [7:0][31:0]  mid;
        logic [15:0][31:0] blk;
        logic [31:0] h0, exp_nonce;
        logic [15:0] maddr, oaddr;
        logic exp_found;
        int nb, cyc, idx, n;

        maddr = 16'($urandom_range(0, 16'h3fff));
        oaddr = 16'($urandom_range(16'h8000, 16'hbfff));
        for (int j = 0; j < 20; j++) begin
            hdr[j] = $urandom;
            mem[maddr + 16'(j)] = hdr[j];
        end
        for (int j = 0; j < 16; j++) blk[j] = hdr[j];
        mid = compress(iv_vec(), blk);

        exp_q.delete();
        exp_found = 1'b0; exp_nonce = '0; nb = 0;
        for (int b = 0; b * NL < count; b++) begin
            nb++;
            for (int l = 0; l < NL; l++) begin
                idx = b * NL + l;
                if (idx < count) begin
                    h0 = h0_of(mid, base + 32'(idx));
                    exp_q.push_back({oaddr + 16'(idx), h0});
                    if (h0 < tgt && !exp_found) begin
                        exp_found = 1'b1;
                        exp_nonce = base + 32'(idx);
                    end
                end
            end
            if (stop && exp_found) break;
        end

        @(posedge clk); #1;
        act_q.delete();
        message_addr = maddr; output_addr = oaddr; nonce_base = base;
        nonce_count = CW'(count); target = tgt; stop_on_found = stop; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Inputs are captured at start; scramble them for the rest of the run.
        message_addr = 16'($urandom); output_addr = 16'($urandom); nonce_base = $urandom;
        nonce_count = CW'($urandom); target = $urandom; stop_on_found = 1'($urandom);
        cyc = 1;
        check({name, "_busy"}, done, 1'b0);
        while (done !== 1'b1 && cyc < BUDGET) begin
            start = (cyc == 40);  // ignored while busy
            @(posedge clk); #1;
            cyc++;
            if (cyc == rst_at) begin
                check({name, "_we_before_rst"}, bus.mem_we, 1'b1);
                #2 reset_n = 1'b0;
                #1;
                check({name, "_rst_we"}, bus.mem_we, 1'b0);
                check({name, "_rst_done"}, done, 1'b1);
                check({name, "_rst_found"}, found, 1'b0);
                #2 reset_n = 1'b1;
                start = 1'b0;
                act_q.delete();
                repeat (20) @(posedge clk);
                #1;
                check({name, "_rst_no_writes"}, act_q.size(), 0);
                check({name, "_rst_idle"}, done, 1'b1);
                return;
            end
        end
        start = 1'b0;
        check({name, "_done"}, done, 1'b1);
        if (count > 0) check({name, "_cycles"}, cyc, 1 + 21 + 67 + nb * (134 + NL + 1));
        else           check({name, "_cycles"}, cyc, 1 + 21);
        check({name, "_nwrites"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({name, "_write"}, act_q[i], exp_q[i]);
        check({name, "_found"}, found, exp_found);
        check({name, "_found_nonce"}, found_nonce, exp_nonce);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_found_hold"}, {found, found_nonce}, {exp_found, exp_nonce});
        check({name, "_idle_no_writes"}, act_q.size(), exp_q.size());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0][31:0] abc;
        logic [7:0][31:0]  dg;
        abc = '0; abc[0] = 32'h6162_6380; abc[15] = 32'h18;
        dg = compress(iv_vec(), abc);
        check("model_abc", dg[0], 32'hba7816bf);

        #23;
        check("rst_done", done, 1'b1);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_addr", bus.mem_addr, 16'h0);
        check("rst_wdata", bus.mem_write_data, 32'h0);
        check("rst_found", found, 1'b0);
        check("rst_found_nonce", found_nonce, 32'h0);
        check("mem_clk", bus.mem_clk, clk);
        reset_n = 1'b1;

        run(32'h0, 16, 32'h0, 1'b0, "s1_basic", 0);
        run($urandom, 20, $urandom, 1'b0, "s2_partial", 0);
        run(32'h5, 8, 32'hffff_ffff, 1'b0, "s3_allhit", 0);
        run($urandom, 64, 32'hffff_ffff, 1'b1, "s4_stop", 0);
        run(32'hffff_fffe, 4, $urandom, 1'b0, "s5_wrap", 0);
        run(32'h0, 16, 32'h0, 1'b0, "s6_reset", 226);
        run(32'h0, 16, 32'h0, 1'b0, "s6_rerun", 0);
        run($urandom, 0, 32'hffff_ffff, 1'b0, "count0", 0);
        repeat (3) run($urandom, $urandom_range(1, 24), $urandom, 1'($urandom_range(0, 1)), "rand", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
